// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the LC-3 memory controller: device map, status bit
// positions and the access-sequencer state type.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RDY  = 2'd2
  } acc_state_e;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

  localparam int BIT_RDY = 15;
  localparam int BIT_IE  = 14;

  // The whole xFE00-xFFFF page belongs to I/O, mapped or not.
  function automatic logic is_io_addr(input logic [15:0] addr);
    return addr[15:9] == 7'h7F;
  endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port RAM: synchronous write, registered read.
module ram_sp #(
  parameter int    ADDR_W   = 16,
  parameter int    DATA_W   = 16,
  parameter string MEM_FILE = ""
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tsb_h.sv
// Tristate bus buffer: drives the shared bus only while enabled.
module tsb_h #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic         i_en,
  output wire  [W-1:0] o_y
);

  assign o_y = i_en ? i_a : {W{1'bz}};

endmodule

// File: rtl/mem_ctrl.sv
// LC-3 memory controller: MAR/MDR, memory-mapped keyboard/display/MCR and
// the MIO.EN access sequencer that produces mem_rdy.
//   state   | meaning
//   IDLE    | no access; mio_en starts one
//   WAIT    | RAM latency countdown, abort if mio_en drops
//   RDY     | mem_rdy high; read/write commits at the edge
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int    ADDR_W      = 16,
  parameter int    MEM_LATENCY = 4,
  parameter string MEM_FILE    = ""
) (
  input  logic       clk,
  input  logic       arst_n,
  inout  wire [15:0] bus,
  input  logic       mem_ld_mar,
  input  logic       mem_ld_mdr,
  input  logic       mem_gate_mdr,
  input  logic       mem_mio_en,
  input  logic       mem_rw,
  output logic       mem_rdy,
  input  logic       kb_valid,
  input  logic [7:0] kb_data,
  output logic       kb_ready,
  output logic       disp_valid,
  output logic [7:0] disp_data,
  input  logic       disp_ack,
  output logic       kb_irq,
  output logic       run
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  acc_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [15:0] r_mar, r_mdr, r_ddr;
  logic [7:0]  r_kbdr;
  logic        r_kb_full, r_kb_ie, r_dsr_rdy, r_dsr_ie, r_mcr_run;

  logic        w_is_io, w_commit_rd, w_commit_wr, w_kbdr_rd, w_kb_accept, w_bus_en;
  logic [15:0] w_ram_rdata, w_dev_rdata, w_rd_data;

  assign w_is_io     = is_io_addr(r_mar);
  assign w_commit_rd = (r_state == ST_RDY) && !mem_rw;
  assign w_commit_wr = (r_state == ST_RDY) && mem_rw;
  assign w_kbdr_rd   = w_commit_rd && (r_mar == ADDR_KBDR);
  // A KBDR read clearing the flag beats a new char in the same cycle.
  assign w_kb_accept = kb_valid && !r_kb_full && !w_kbdr_rd;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (mem_mio_en) begin
          w_cnt_nxt   = CNT_W'(MEM_LATENCY - 1);
          w_state_nxt = (w_is_io || MEM_LATENCY == 1) ? ST_RDY : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!mem_mio_en) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nxt = ST_RDY;
        end
      end
      ST_RDY:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_dev_rdata = '0;
    case (r_mar)
      ADDR_KBSR: w_dev_rdata = {r_kb_full, r_kb_ie, 14'b0};
      ADDR_KBDR: w_dev_rdata = {8'b0, r_kbdr};
      ADDR_DSR:  w_dev_rdata = {r_dsr_rdy, r_dsr_ie, 14'b0};
      ADDR_DDR:  w_dev_rdata = r_ddr;
      ADDR_MCR:  w_dev_rdata = {r_mcr_run, 15'b0};
      default:   w_dev_rdata = '0;
    endcase
  end

  assign w_rd_data = w_is_io ? w_dev_rdata : w_ram_rdata;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_mar     <= '0;
      r_mdr     <= '0;
      r_ddr     <= '0;
      r_kbdr    <= '0;
      r_kb_full <= 1'b0;
      r_kb_ie   <= 1'b0;
      r_dsr_rdy <= 1'b1;
      r_dsr_ie  <= 1'b0;
      r_mcr_run <= 1'b1;
    end else begin
      if (mem_ld_mar) r_mar <= bus;

      if (w_commit_rd && mem_ld_mdr) r_mdr <= w_rd_data;
      else if (mem_ld_mdr && !mem_mio_en) r_mdr <= bus;

      if (w_commit_wr && w_is_io) begin
        case (r_mar)
          ADDR_KBSR: r_kb_ie <= r_mdr[BIT_IE];
          ADDR_DSR:  r_dsr_ie <= r_mdr[BIT_IE];
          ADDR_DDR: begin
            if (r_dsr_rdy) begin
              r_ddr     <= r_mdr;
              r_dsr_rdy <= 1'b0;
            end
          end
          ADDR_MCR:  r_mcr_run <= r_mdr[BIT_RDY];
          default: ;
        endcase
      end

      if (disp_ack && !r_dsr_rdy) r_dsr_rdy <= 1'b1;

      if (w_kbdr_rd) begin
        r_kb_full <= 1'b0;
      end else if (w_kb_accept) begin
        r_kb_full <= 1'b1;
        r_kbdr    <= kb_data;
      end
    end
  end

  ram_sp #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (16),
    .MEM_FILE(MEM_FILE)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_commit_wr && !w_is_io),
    .i_addr (r_mar[ADDR_W-1:0]),
    .i_wdata(r_mdr),
    .o_rdata(w_ram_rdata)
  );

  assign w_bus_en = mem_gate_mdr && arst_n;

  tsb_h #(.W(16)) u_bus_drv (
    .i_a (r_mdr),
    .i_en(w_bus_en),
    .o_y (bus)
  );

  assign mem_rdy    = (r_state == ST_RDY);
  assign kb_ready   = !r_kb_full;
  assign disp_valid = !r_dsr_rdy;
  assign disp_data  = r_ddr[7:0];
  assign kb_irq     = r_kb_full && r_kb_ie;
  assign run        = r_mcr_run;

endmodule
